rv32i_dmem_xbar: RTL
====================

// Module: rv32i_dmem_xbar
// PURPOSE
//  Data-side interconnect for the RV32I core: two initiators (CPU LSU, external loader/debug) to NUM_TGT targets
//  (target 0 = DTCM, others = bus slaves) via req/gnt/rvalid handshake. Address-region decode, round-robin
//  arbitration, response routing, error response for unmapped addresses. Sits between RV32I_top, RV32I_dtcm and bus.
// PARAMETERS
//  WORD_WTH      32             data width
//  ADDR_WTH      32             address width
//  MASK_WTH      4              byte-enable width (WORD_WTH/8)
//  NUM_TGT       2              number of targets, 1..8
//  REGION_SHIFT  16             region = addr >> REGION_SHIFT
//  TGT_BASE      {16'h2000,16'h1000}  packed NUM_TGT x (ADDR_WTH-REGION_SHIFT) region tags, entry i = target i
//  TIMEOUT_CYC   255            response timeout in cycles (only with DMEM_XBAR_TIMEOUT_EN)
// PORTS
//  clk         in   1                  clock
//  rst         in   1                  synchronous reset, active-low
//  ini_req     in   2                  request per initiator, bit0=CPU, bit1=EXT
//  ini_we      in   2                  write enable per initiator
//  ini_be      in   2*MASK_WTH         byte enables
//  ini_addr    in   2*ADDR_WTH         address
//  ini_wdata   in   2*WORD_WTH         write data
//  ini_gnt     out  2                  request accepted (one-hot or zero)
//  ini_rvalid  out  2                  response valid, 1-cycle pulse (reads and writes)
//  ini_rdata   out  WORD_WTH           read data, shared, qualified by ini_rvalid
//  ini_err     out  1                  error flag, qualified by ini_rvalid
//  tgt_req     out  NUM_TGT            request per target (one-hot or zero)
//  tgt_we      out  1                  write enable (shared)
//  tgt_be      out  MASK_WTH           byte enables (shared)
//  tgt_addr    out  ADDR_WTH           full address (shared)
//  tgt_wdata   out  WORD_WTH           write data (shared)
//  tgt_gnt     in   NUM_TGT            target accepted request
//  tgt_rvalid  in   NUM_TGT            target response valid (writes too)
//  tgt_rdata   in   NUM_TGT*WORD_WTH   target read data
// BEHAVIOUR
//  - Reset (rst==0 at clk edge): state IDLE, rr_last=EXT (CPU wins first tie); ini_gnt/ini_rvalid/ini_err=0,
//    ini_rdata=0, tgt_req=0. Outstanding transaction dropped; late tgt_rvalid afterwards ignored.
//  - One outstanding transaction total. FSM: IDLE, WAIT_RSP, ERR_RSP.
//  - IDLE: arbitrate ini_req; single requester wins; both -> winner = !rr_last. Decode winner addr: hit i if
//    addr>>REGION_SHIFT == TGT_BASE[i]; lowest i wins on multiple hits. Hit: drive tgt_req[i] + shared payload
//    combinationally; ini_gnt[w] = tgt_gnt[i] same cycle. On gnt: latch w, i; rr_last<=w; -> WAIT_RSP.
//    Miss: ini_gnt[w]=1 immediately, no tgt_req; -> ERR_RSP.
//  - WAIT_RSP: no grants, tgt_req=0. On tgt_rvalid[i]: ini_rvalid[w]=1, ini_rdata=tgt_rdata[i], ini_err=0 (registered,
//    1 cycle after tgt_rvalid); -> IDLE. tgt_rvalid from other targets ignored.
//  - ERR_RSP: ini_rvalid[w]=1, ini_err=1, ini_rdata=0 next cycle; -> IDLE.
//  - Latency: hit = tgt grant-to-rvalid + 1; miss = gnt cycle + 1. Min 1 idle cycle between responses and next grant.
//  - Initiators hold req/payload stable until gnt; req drop before gnt is legal, no side effects.
//  - ini_rdata/ini_err hold last value when ini_rvalid=0.
// CONFIGURATION
//  DMEM_XBAR_TIMEOUT_EN defined: 8..16-bit counter cleared on WAIT_RSP entry; at TIMEOUT_CYC cycles without
//  tgt_rvalid[i]: ini_rvalid[w]=1, ini_err=1, ini_rdata=0, -> IDLE; late rvalid from i dropped.
//  Not defined: WAIT_RSP waits indefinitely; no counter logic.
// STRUCTURE
//  RV32I_defines.v: DTCM_START, BUS_START, XBAR_IDLE/WAIT_RSP/ERR_RSP encodings, INI_CPU=0/INI_EXT=1.
//  Sub-module rv32i_rr_arbiter: 2-way round-robin (req[1:0], rr_last -> gnt one-hot); decode/FSM in top.
// TESTING
//  1 CPU read 0x1000_0040, DTCM gnt same cycle, rvalid+1 rdata 0xDEADBEEF -> ini_gnt[0] cyc0, ini_rvalid[0]+ rdata next cycle, err=0.
//  2 CPU+EXT req to 0x1000_0000 same cycle after reset -> CPU granted first, EXT next transaction; repeat -> alternate.
//  3 EXT write 0x2000_0004 be=4'b0011, bus gnt delayed 3 cycles -> tgt_req[1] held 3 cycles, ini_gnt[1] on 4th, write ack rvalid.
//  4 CPU read 0x3000_0000 (unmapped) -> ini_gnt[0] same cycle, next cycle rvalid=1 err=1 rdata=0, no tgt_req.
//  5 rst=0 in WAIT_RSP, then tgt_rvalid[0] -> all outputs 0, state IDLE, late rvalid not forwarded.
//  6 TIMEOUT_EN, TIMEOUT_CYC=8, bus never rvalids -> err response 8 cycles after gnt; without macro bench sees hang until rvalid.

Source files
------------

// File: rtl/rv32i_dmem_xbar_pkg.sv
// Shared types and constants for the RV32I data-memory crossbar.
package rv32i_dmem_xbar_pkg;

  // Initiator indices: bit 0 is the CPU LSU, bit 1 the external loader/debug port.
  localparam int unsigned NumIni = 2;
  localparam int unsigned IniCpu = 0;
  localparam int unsigned IniExt = 1;

  typedef enum logic [1:0] {
    StIdle    = 2'd0,
    StWaitRsp = 2'd1,
    StErrRsp  = 2'd2
  } xbar_state_e;

  // One-hot initiator vector from an initiator index.
  function automatic logic [NumIni-1:0] ini_onehot(input logic idx);
    return idx ? 2'b10 : 2'b01;
  endfunction

endpackage

// File: rtl/rv32i_rr_arbiter.sv
// Two-way round-robin arbiter: a lone requester wins; on a tie the initiator
// that did not win last time is granted.
module rv32i_rr_arbiter (
  input  logic [1:0] i_req,
  input  logic       i_rr_last,
  output logic [1:0] o_gnt
);

  // Pick the winner from the request pair and the last winner.
  always_comb begin
    o_gnt = 2'b00;
    unique case (i_req)
      2'b01:   o_gnt = 2'b01;
      2'b10:   o_gnt = 2'b10;
      2'b11:   o_gnt = i_rr_last ? 2'b01 : 2'b10;
      default: o_gnt = 2'b00;
    endcase
  end

endmodule

// File: rtl/rv32i_dmem_xbar.sv
// Data-side interconnect: two initiators (CPU, EXT) to NUM_TGT targets with region decode,
// round-robin arbitration, response routing and error responses for unmapped addresses.
// Optional response timeout enabled by defining DMEM_XBAR_TIMEOUT_EN.
module rv32i_dmem_xbar
  import rv32i_dmem_xbar_pkg::*;
#(
  parameter int unsigned WORD_WTH     = 32,
  parameter int unsigned ADDR_WTH     = 32,
  parameter int unsigned MASK_WTH     = 4,
  parameter int unsigned NUM_TGT      = 2,
  parameter int unsigned REGION_SHIFT = 16,
  parameter logic [NUM_TGT*(ADDR_WTH-REGION_SHIFT)-1:0] TGT_BASE = {16'h2000, 16'h1000}
`ifdef DMEM_XBAR_TIMEOUT_EN
  ,
  parameter int unsigned TIMEOUT_CYC  = 255
`endif
) (
  input  logic                        i_clk,
  input  logic                        i_rst,
  input  logic [1:0]                  i_ini_req,
  input  logic [1:0]                  i_ini_we,
  input  logic [2*MASK_WTH-1:0]       i_ini_be,
  input  logic [2*ADDR_WTH-1:0]       i_ini_addr,
  input  logic [2*WORD_WTH-1:0]       i_ini_wdata,
  output logic [1:0]                  o_ini_gnt,
  output logic [1:0]                  o_ini_rvalid,
  output logic [WORD_WTH-1:0]         o_ini_rdata,
  output logic                        o_ini_err,
  output logic [NUM_TGT-1:0]          o_tgt_req,
  output logic                        o_tgt_we,
  output logic [MASK_WTH-1:0]         o_tgt_be,
  output logic [ADDR_WTH-1:0]         o_tgt_addr,
  output logic [WORD_WTH-1:0]         o_tgt_wdata,
  input  logic [NUM_TGT-1:0]          i_tgt_gnt,
  input  logic [NUM_TGT-1:0]          i_tgt_rvalid,
  input  logic [NUM_TGT*WORD_WTH-1:0] i_tgt_rdata
);

  localparam int unsigned TagW    = ADDR_WTH - REGION_SHIFT;
  localparam int unsigned TgtIdxW = (NUM_TGT > 1) ? $clog2(NUM_TGT) : 1;

  xbar_state_e          r_state, w_state_nxt;
  logic                 r_rr_last;
  logic                 r_win;
  logic [TgtIdxW-1:0]   r_tgt;
  logic [1:0]           r_rvalid;
  logic [WORD_WTH-1:0]  r_rdata;
  logic                 r_err;

  logic [1:0]           w_arb_gnt;
  logic                 w_win;
  logic                 w_any_req;
  logic [ADDR_WTH-1:0]  w_win_addr;
  logic                 w_hit;
  logic [TgtIdxW-1:0]   w_hit_idx;
  logic                 w_can_grant;
  logic                 w_take_hit;
  logic                 w_take_miss;
  logic                 w_tgt_rv;
  logic [WORD_WTH-1:0]  w_rsp_rdata;
  logic                 w_rsp_hit;
  logic                 w_tmo;

  rv32i_rr_arbiter u_arb (
    .i_req     (i_ini_req),
    .i_rr_last (r_rr_last),
    .o_gnt     (w_arb_gnt)
  );

  assign w_win     = w_arb_gnt[IniExt];
  assign w_any_req = w_arb_gnt[IniCpu] | w_arb_gnt[IniExt];

  // Shared target payload follows the current arbitration winner.
  always_comb begin
    w_win_addr  = w_win ? i_ini_addr[ADDR_WTH +: ADDR_WTH] : i_ini_addr[0 +: ADDR_WTH];
    o_tgt_addr  = w_win_addr;
    o_tgt_we    = w_win ? i_ini_we[1] : i_ini_we[0];
    o_tgt_be    = w_win ? i_ini_be[MASK_WTH +: MASK_WTH] : i_ini_be[0 +: MASK_WTH];
    o_tgt_wdata = w_win ? i_ini_wdata[WORD_WTH +: WORD_WTH] : i_ini_wdata[0 +: WORD_WTH];
  end

  // Region decode; scanning downwards lets the lowest matching target win.
  always_comb begin
    w_hit     = 1'b0;
    w_hit_idx = '0;
    for (int i = int'(NUM_TGT) - 1; i >= 0; i--) begin
      if (w_win_addr[ADDR_WTH-1:REGION_SHIFT] == TGT_BASE[i*TagW +: TagW]) begin
        w_hit     = 1'b1;
        w_hit_idx = TgtIdxW'(i);
      end
    end
  end

  // Response selection from the latched target.
  always_comb begin
    w_tgt_rv    = 1'b0;
    w_rsp_rdata = '0;
    for (int i = 0; i < int'(NUM_TGT); i++) begin
      if (r_tgt == TgtIdxW'(i)) begin
        w_tgt_rv    = i_tgt_rvalid[i];
        w_rsp_rdata = i_tgt_rdata[i*WORD_WTH +: WORD_WTH];
      end
    end
  end

  assign w_rsp_hit = (r_state == StWaitRsp) && w_tgt_rv;

  // No grants while in reset or while a response is being presented, which keeps one
  // idle cycle between every response and the next grant.
  assign w_can_grant = i_rst && (r_state == StIdle) && (r_rvalid == 2'b00) && w_any_req;

  // Grant and target request generation.
  always_comb begin
    o_tgt_req   = '0;
    o_ini_gnt   = 2'b00;
    w_take_hit  = 1'b0;
    w_take_miss = 1'b0;
    if (w_can_grant) begin
      if (w_hit) begin
        for (int i = 0; i < int'(NUM_TGT); i++) begin
          o_tgt_req[i] = (w_hit_idx == TgtIdxW'(i));
        end
        if ((i_tgt_gnt & o_tgt_req) != '0) begin
          o_ini_gnt  = ini_onehot(w_win);
          w_take_hit = 1'b1;
        end
      end else begin
        o_ini_gnt   = ini_onehot(w_win);
        w_take_miss = 1'b1;
      end
    end
  end

`ifdef DMEM_XBAR_TIMEOUT_EN
  // Fires on the WAIT_RSP cycle that puts the error response TIMEOUT_CYC cycles after
  // the grant; TIMEOUT_CYC must be at least 2.
  localparam logic [15:0] TmoLast = 16'(TIMEOUT_CYC - 2);
  logic [15:0] r_tmo_cnt;

  // Count cycles spent in WAIT_RSP, cleared by the grant that enters it.
  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      r_tmo_cnt <= '0;
    end else if (w_take_hit) begin
      r_tmo_cnt <= '0;
    end else if (r_state == StWaitRsp) begin
      r_tmo_cnt <= r_tmo_cnt + 16'd1;
    end
  end

  assign w_tmo = (r_state == StWaitRsp) && !w_tgt_rv && (r_tmo_cnt == TmoLast);
`else
  assign w_tmo = 1'b0;
`endif

  // Next-state logic.
  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      StIdle: begin
        if (w_take_hit) begin
          w_state_nxt = StWaitRsp;
        end else if (w_take_miss) begin
          w_state_nxt = StErrRsp;
        end
      end
      StWaitRsp: begin
        if (w_rsp_hit || w_tmo) begin
          w_state_nxt = StIdle;
        end
      end
      StErrRsp: w_state_nxt = StIdle;
      default:  w_state_nxt = StIdle;
    endcase
  end

  // State, transaction context and registered response.
  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      r_state   <= StIdle;
      r_rr_last <= 1'(IniExt);
      r_win     <= 1'b0;
      r_tgt     <= '0;
      r_rvalid  <= 2'b00;
      r_rdata   <= '0;
      r_err     <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_rvalid <= 2'b00;
      if (w_take_hit || w_take_miss) begin
        r_win     <= w_win;
        r_rr_last <= w_win;
      end
      if (w_take_hit) begin
        r_tgt <= w_hit_idx;
      end
      // Unmapped access: error response is presented during the ERR_RSP cycle.
      if (w_take_miss || w_tmo) begin
        r_rvalid <= ini_onehot(w_take_miss ? w_win : r_win);
        r_err    <= 1'b1;
        r_rdata  <= '0;
      end
      if (w_rsp_hit) begin
        r_rvalid <= ini_onehot(r_win);
        r_err    <= 1'b0;
        r_rdata  <= w_rsp_rdata;
      end
    end
  end

  assign o_ini_rvalid = r_rvalid;
  assign o_ini_rdata  = r_rdata;
  assign o_ini_err    = r_err;

endmodule
